muldiv_unit: RTL and testbench

// Iterative multi-cycle unsigned multiply/divide unit that owns the HI/LO register pair.

---
 rtl/muldiv_unit.sv | 112 +++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit that owns the HI/LO pair.
// One shift-add (multu) or restoring-divide (divu) step per cycle, WIDTH steps per op.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wrhi,
    input  logic             wrlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [2*WIDTH-1:0] step;

    // Multiply: acc_hi accumulates partial sums, acc_lo holds the multiplier and
    // collects product bits as the pair shifts right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi_in,
                                                     input logic [WIDTH-1:0] lo_in,
                                                     input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, lo_in[WIDTH-1:1]};
    endfunction

    // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and
    // quotient bits in. A zero divisor never borrows, giving all-ones / dividend.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                     input logic [WIDTH-1:0] quo,
                                                     input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   shifted;
        logic [WIDTH+1:0] diff;
        shifted = {rem, quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, d};
        if (diff[WIDTH+1])
            return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        else
            return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        step = '0;
        if (op_q)
            step = div_step(acc_hi, acc_lo, opnd);
        else
            step = mul_step(acc_hi, acc_lo, opnd);
    end

    // Datapath working registers; their content is meaningless outside RUN.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc_hi <= '0;
            acc_lo <= op ? a : b;
            opnd   <= op ? b : a;
            op_q   <= op;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                    end else begin
                        if (wrhi) hi <= a;
                        if (wrlo) lo <= a;
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    // The last step's result goes straight into hi/lo on the same edge.
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= step[2*WIDTH-1:WIDTH];
                        lo    <= step[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         wrhi = 1'b0;
    logic         wrlo = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wrhi(wrhi), .wrlo(wrlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: results from plain arithmetic, timing from a countdown.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_busy = 1'b0, m_done = 1'b0;
    int           m_left = 0;
    logic [2*W-1:0] prod;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_left = W;
            if (!op) begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                p_hi = prod[2*W-1:W];
                p_lo = prod[W-1:0];
            end else if (b == 0) begin
                p_hi = a; p_lo = '1;
            end else begin
                p_hi = a % b; p_lo = a / b;
            end
        end else begin
            if (wrhi) m_hi = a;
            if (wrlo) m_lo = a;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("model_done", {31'b0, done}, {31'b0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Called just after a negedge; returns just after the negedge following the start edge.
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        cmp_en = 1'b1;

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("mul_max_lat", lat, 32'd32);
        chk("mul_max_hi", hi, 32'hFFFF_FFFE);
        chk("mul_max_lo", lo, 32'h0000_0001);
        chk("mul_max_busy", {31'b0, busy}, 32'd0);

        issue(1'b1, 32'd100, 32'd7);
        wait_done(lat);
        chk("div_100_7_lat", lat, 32'd32);
        chk("div_100_7_lo", lo, 32'd14);
        chk("div_100_7_hi", hi, 32'd2);

        issue(1'b1, 32'd7, 32'd100);
        wait_done(lat);
        chk("div_7_100_lo", lo, 32'd0);
        chk("div_7_100_hi", hi, 32'd7);

        // Back-to-back: start in the done cycle; old result held until the new one lands.
        issue(1'b1, 32'd5, 32'd0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_hold_hi", hi, 32'd7);
        wait_done(lat);
        chk("div0_lat", lat, 32'd32);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd5);
        @(negedge clk);

        issue(1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat, 32'd27);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd12);
        @(negedge clk);
        chk("ign_no_queue", {31'b0, busy}, 32'd0);

        wrhi = 1'b1; a = 32'hA5A5_A5A5;
        @(negedge clk);
        wrhi = 1'b0;
        chk("wrhi_hi", hi, 32'hA5A5_A5A5);
        wrlo = 1'b1; a = 32'h5A5A_5A5A;
        @(negedge clk);
        wrlo = 1'b0;
        chk("wrlo_lo", lo, 32'h5A5A_5A5A);
        chk("wrlo_hi_kept", hi, 32'hA5A5_A5A5);
        wrhi = 1'b1; wrlo = 1'b1; a = 32'h0F0F_0F0F;
        @(negedge clk);
        wrhi = 1'b0; wrlo = 1'b0;
        chk("wrboth_hi", hi, 32'h0F0F_0F0F);
        chk("wrboth_lo", lo, 32'h0F0F_0F0F);
        wrlo = 1'b1; start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        wrlo = 1'b0; start = 1'b0;
        chk("wrlo_start_dropped", lo, 32'h0F0F_0F0F);
        wrhi = 1'b1; a = 32'h1234_5678;
        @(negedge clk);
        wrhi = 1'b0;
        chk("wrhi_busy_ignored", hi, 32'h0F0F_0F0F);
        wait_done(lat);
        chk("wr_run_lat", lat, 32'd31);
        chk("wr_run_lo", lo, 32'd15);
        chk("wr_run_hi", hi, 32'd0);
        @(negedge clk);

        issue(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        issue(1'b0, 32'd6, 32'd7);
        wait_done(lat);
        chk("after_abort_lat", lat, 32'd32);
        chk("after_abort_lo", lo, 32'd42);
        chk("after_abort_hi", hi, 32'd0);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
